// File: rtl/fir_decim_rescale.sv
// Boxcar decimator (R = 2^DEC_LOG2) followed by round-half-up rescale and saturation to OUT_WIDTH.
// Define FIR_DECIM_SAT_FLAG_EN to build the sticky sat_flag; otherwise sat_flag is tied low.
module fir_decim_rescale #(
  parameter int IN_WIDTH  = 30,
  parameter int OUT_WIDTH = 16,
  parameter int DEC_LOG2  = 3,
  parameter int SHIFT     = 13
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        clr,
  input  logic                        din_valid,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        dout_valid,
  output logic                        sat_flag,
  input  logic                        sat_clr
);

  localparam int ACC_W = IN_WIDTH + DEC_LOG2;
  localparam int RND_W = ACC_W + 1;
  localparam int K     = DEC_LOG2 + SHIFT;
  localparam int PH_W  = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DEC_LOG2) - 1);
  localparam logic signed [RND_W-1:0] HALF = RND_W'(1) << (K - 1);
  localparam logic signed [RND_W-1:0] OMAX =
    {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] OMIN =
    {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     r_sum;
  logic [PH_W-1:0]             r_ph;
  logic                        r_blk;

  logic signed [ACC_W-1:0]     w_din_ext;
  logic signed [ACC_W-1:0]     w_acc_nxt;
  logic signed [RND_W-1:0]     w_rnd;
  logic signed [RND_W-1:0]     w_r;
  logic                        w_hi;
  logic                        w_lo;
  logic                        w_emit;
  logic signed [OUT_WIDTH-1:0] w_clamped;

  assign w_din_ext = ACC_W'(din);
  assign w_acc_nxt = r_acc + w_din_ext;

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  assign w_rnd  = RND_W'(r_sum) + HALF;
  assign w_r    = w_rnd >>> K;
  assign w_hi   = w_r > OMAX;
  assign w_lo   = w_r < OMIN;
  assign w_emit = r_blk & ~clr;

  always_comb begin
    w_clamped = w_r[OUT_WIDTH-1:0];
    if (w_hi)
      w_clamped = OMAX[OUT_WIDTH-1:0];
    else if (w_lo)
      w_clamped = OMIN[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc <= '0;
      r_sum <= '0;
      r_ph  <= '0;
      r_blk <= 1'b0;
    end else if (clr) begin
      r_acc <= '0;
      r_ph  <= '0;
      r_blk <= 1'b0;
    end else begin
      r_blk <= 1'b0;
      if (din_valid) begin
        if (r_ph == PH_LAST) begin
          r_sum <= w_acc_nxt;
          r_acc <= '0;
          r_ph  <= '0;
          r_blk <= 1'b1;
        end else begin
          r_acc <= w_acc_nxt;
          r_ph  <= r_ph + PH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= w_emit;
      if (w_emit)
        dout <= w_clamped;
    end
  end

`ifdef FIR_DECIM_SAT_FLAG_EN
  logic r_sat;

  // A saturating write on the same edge as sat_clr keeps the flag set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_sat <= 1'b0;
    else if (w_emit && (w_hi || w_lo))
      r_sat <= 1'b1;
    else if (sat_clr)
      r_sat <= 1'b0;
  end

  assign sat_flag = r_sat;
`else
  logic w_unused_sat_clr;

  assign w_unused_sat_clr = sat_clr;
  assign sat_flag         = 1'b0;
`endif

endmodule

// File: doc/fir_decim_rescale.md
# fir_decim_rescale

Post-filter stage that consumes the wide signed output of the 32-tap, 14-bit FIR filter (`myfir_filter`, 30-bit `dout`) and turns it into a narrow, decimated sample stream. It performs boxcar accumulation over 2^DEC_LOG2 input samples, then arithmetic rescale, round-half-up and saturation to OUT_WIDTH. It emits a single-cycle valid strobe per output word. It sits directly downstream of the FIR in the IRIS filter chain and feeds the demodulation/readout logic.

## Interface
- IN_WIDTH, 30, signed input width; matches FIR `dout` (WIDTH+16).
- OUT_WIDTH, 16, signed output width.
- DEC_LOG2, 3, log2 of decimation ratio R (R = 8 by default); legal range 0..6.
- SHIFT, 13, extra right shift removing FIR coefficient gain; legal range 1..(IN_WIDTH-1).
- clk  in  1  system clock (100 MHz).
- n_rst  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear; restarts the decimation phase and discards any partial sum.
- din_valid  in  1  din qualifier; tie high when the FIR runs every clock.
- din  in  IN_WIDTH  signed FIR output sample.
- dout  out  OUT_WIDTH  signed decimated, rescaled, saturated sample.
- dout_valid  out  1  one-cycle strobe marking a new dout.
- sat_flag  out  1  sticky saturation indicator (see Configuration).
- sat_clr  in  1  synchronous clear of sat_flag.

## Operation
- Phase counter `ph` (DEC_LOG2 bits) counts accepted samples (din_valid=1); wraps R-1 -> 0.
- Accumulator `acc` is IN_WIDTH+DEC_LOG2 bits signed and sign-extends din.
  - On an accepted sample with ph < R-1: acc <= acc + din.
  - On an accepted sample with ph = R-1: capture sum = acc + din into a block register, acc <= 0, ph <= 0, and set an internal `blk` pulse.
- Stage 2, on `blk`:
  - Compute k = DEC_LOG2 + SHIFT and r = (sum + 2^(k-1)) >>> k (arithmetic; round half toward +inf).
  - Clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the result to dout and assert dout_valid.
- Guard bits: the round add is performed at width IN_WIDTH+DEC_LOG2+1 so it cannot wrap.
- dout holds its value between strobes.
- din_valid=0: no accumulation, ph holds; gaps of any length are allowed.
- clr=1: acc <= 0, ph <= 0, pending `blk` cancelled, so no dout_valid results from the aborted block. dout holds its value.
  - clr with din_valid on the same cycle: clr wins and the sample is dropped.
- sat_clr together with a saturating result on the same edge: set wins.

## Timing
- Reset (n_rst=0, async): acc=0, ph=0, blk=0, dout=0, dout_valid=0, sat_flag=0.
- Latency: R-th accepted sample at edge k -> blk at edge k -> dout/dout_valid at edge k+1. dout_valid is high for exactly one cycle.
- With din_valid continuously high: one strobe every R clocks. First strobe at the (R+1)-th edge after reset release.
- Reset asserted mid-block: partial sum lost; the first block after release starts at ph=0.
- DEC_LOG2=0: every accepted sample produces a strobe one edge later.
- Fully pipelined, no backpressure; the consumer must accept each strobe.

## Configuration
- Macro FIR_DECIM_SAT_FLAG_EN.
- Defined: sat_flag sets at the edge dout is written with a clamped value, stays high until sat_clr=1 or reset.
- Undefined: the flag logic is not built and sat_flag is tied to 0. sat_clr is ignored. Clamping of dout still always occurs.

## Test plan
All scenarios use default parameters (k = 16).
- Constant din=819200, din_valid=1 -> dout=100 every 8 clocks; first dout_valid on the 9th edge after reset release.
- Constant din=-819200 -> dout=-100.
- Rounding, din=4096 -> dout=1. din=-4096 -> dout=0 (half rounds up). din=4095 -> dout=0.
- Saturation, din=536870911 -> dout=32767. din=-536870912 -> dout=-32768.
  - With FIR_DECIM_SAT_FLAG_EN, sat_flag=1 until sat_clr pulses.
  - Without the macro, sat_flag stays 0.
- din_valid toggling 1/0, din=819200 -> a strobe every 16 clocks, dout=100. Then clr asserted after 5 accepted samples -> no strobe for that block; the next strobe comes after 8 further accepted samples.
- n_rst pulsed low after 4 accepted samples -> all outputs 0 immediately. The next strobe needs 8 fresh samples, with no contribution from the pre-reset samples.
